// File: rtl/dna_reader.sv
// Reads one network's gene words from external RAM and streams them out over a valid/ready port.
// Optional macro GENE_RANGE_CHECK_EN enables the per-gene source-id range flag on geneError.
module dna_reader #(
    parameter int INPUT_COUNT             = 1,
    parameter int OUTPUT_COUNT            = 1,
    parameter int NEURON_COUNT            = 2,
    parameter int CONNECTIONS             = 2,
    parameter int NETWORKS_PER_POPULATION = 16,
    localparam int GPN   = OUTPUT_COUNT + NEURON_COUNT * CONNECTIONS,
    localparam int NET_W = $clog2(NETWORKS_PER_POPULATION),
    localparam int IDX_W = $clog2(GPN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NET_W-1:0] networkIndex,
    output logic             busy,
    output logic             done,
    output logic [15:0]      geneData,
    output logic [IDX_W-1:0] geneIndex,
    output logic             geneValid,
    input  logic             geneReady,
    output logic             geneError,
    input  logic [15:0]      ramBusDataOut,
    output logic [23:1]      ramBusAddr,
    output logic             ramLatch,
    input  logic             ramReady,
    output logic             ramInstruction
);

    localparam logic             RAM_READ = 1'b0;
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(GPN - 1);
    localparam logic [NET_W:0]   NET_LIM  = (NET_W + 1)'(NETWORKS_PER_POPULATION);

    // Elaboration-time sanity check on the configuration.
    generate
        if (INPUT_COUNT < 1 || NETWORKS_PER_POPULATION < 2 || GPN < 2) begin : g_bad_cfg
            $error("dna_reader: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DATA,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_latch;
    logic [23:1]      r_addr;
    logic [23:1]      r_base;
    logic [IDX_W-1:0] r_k;
    logic             r_valid;
    logic [15:0]      r_data;
    logic [IDX_W-1:0] r_index;
    logic             r_err;

    state_t           w_state_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic             w_latch_next;
    logic [23:1]      w_addr_next;
    logic [23:1]      w_base_next;
    logic [IDX_W-1:0] w_k_next;
    logic             w_valid_next;
    logic [15:0]      w_data_next;
    logic [IDX_W-1:0] w_index_next;
    logic             w_err_next;

    logic             w_idx_bad;
    logic [23:1]      w_base_calc;
    logic             w_gene_bad;

    assign w_idx_bad   = ({1'b0, networkIndex} >= NET_LIM);
    // Word 0 is never written by the initializer, so network data starts at word 1.
    assign w_base_calc = 23'd1 + 23'(networkIndex) * 23'(GPN);

`ifdef GENE_RANGE_CHECK_EN
    localparam logic [15:0] SRC_LIMIT = 16'(OUTPUT_COUNT + NEURON_COUNT + 1);
    assign w_gene_bad = (ramBusDataOut >= SRC_LIMIT);
`else
    assign w_gene_bad = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_latch_next = 1'b0;
        w_addr_next  = r_addr;
        w_base_next  = r_base;
        w_k_next     = r_k;
        w_valid_next = r_valid;
        w_data_next  = r_data;
        w_index_next = r_index;
        w_err_next   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_busy_next = 1'b1;
                    if (w_idx_bad) begin
                        w_done_next  = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_base_next  = w_base_calc;
                        w_k_next     = '0;
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (ramReady) begin
                    w_addr_next  = r_base + 23'(r_k);
                    w_latch_next = 1'b1;
                    w_state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!ramReady) begin
                    w_state_next = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (ramReady) begin
                    w_data_next  = ramBusDataOut;
                    w_index_next = r_k;
                    w_err_next   = w_gene_bad;
                    w_valid_next = 1'b1;
                    w_state_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (geneReady) begin
                    w_valid_next = 1'b0;
                    if (r_k == K_LAST) begin
                        w_done_next  = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_k_next     = r_k + 1'b1;
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                // done is high during this state while busy is still set, so a start here is ignored.
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_latch <= 1'b0;
            r_addr  <= '0;
            r_base  <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_latch <= w_latch_next;
            r_addr  <= w_addr_next;
            r_base  <= w_base_next;
            r_k     <= w_k_next;
            r_valid <= w_valid_next;
            r_data  <= w_data_next;
            r_index <= w_index_next;
            r_err   <= w_err_next;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign geneData       = r_data;
    assign geneIndex      = r_index;
    assign geneValid      = r_valid;
    assign geneError      = r_err;
    assign ramBusAddr     = r_addr;
    assign ramLatch       = r_latch;
    assign ramInstruction = RAM_READ;

endmodule
